// File: rtl/audio_mix_pkg.sv
// rtl/audio_mix_pkg.sv - shared types, widths and saturation helper for the audio mixer
package audio_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    localparam int SAMPLE_W  = 16;
    localparam int GAIN_W    = 5;
    localparam int PROD_W    = 21;
    localparam int ACC_W     = 25;
    localparam int VOL_UNITY = 16;
    localparam int SHIFT     = 4;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 25'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -25'sd32768;

    // Remove the unity-gain scaling (floor division by 16) and clamp to the 16-bit range.
    function automatic logic signed [SAMPLE_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> SHIFT;
        if (sh > SAT_MAX) begin
            return 16'sh7fff;
        end else if (sh < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return sh[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mix_mac.sv
// rtl/mix_mac.sv - shared gain multiplier, gain clamp and left/right accumulators
module mix_mac
    import audio_mix_pkg::*;
#(
    parameter int VOL_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       step_en,
    input  logic                       chan,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [VOL_W-1:0]    vol,
    input  logic                       enable,
    output logic signed [ACC_W-1:0]    acc_left,
    output logic signed [ACC_W-1:0]    acc_right
);

    logic        [31:0]       vol_ext;
    logic        [GAIN_W-1:0] gain;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  addend;

    // Clamp gain to unity, force zero for disabled sources, and form the sign-extended product.
    always_comb begin
        vol_ext = 32'(vol);
        gain    = '0;
        if (enable) begin
            gain = (vol_ext > 32'(VOL_UNITY)) ? GAIN_W'(VOL_UNITY) : vol_ext[GAIN_W-1:0];
        end
        product = $signed({{(PROD_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample})
                * $signed({{(PROD_W-GAIN_W){1'b0}}, gain});
        addend  = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    end

    // Accumulate one product per step into the channel selected by chan (0 = left).
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_left  <= '0;
            acc_right <= '0;
        end else if (clear) begin
            acc_left  <= '0;
            acc_right <= '0;
        end else if (step_en) begin
            if (chan) begin
                acc_right <= acc_right + addend;
            end else begin
                acc_left <= acc_left + addend;
            end
        end
    end

endmodule

// File: rtl/audio_mix_sched.sv
// rtl/audio_mix_sched.sv - frame scheduler: snapshot, time-multiplexed mixing and saturation
module audio_mix_sched
    import audio_mix_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int VOL_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         next_sample,
    input  logic [SAMPLE_W*NUM_SRC-1:0]  src_left,
    input  logic [SAMPLE_W*NUM_SRC-1:0]  src_right,
    input  logic [VOL_W*NUM_SRC-1:0]     src_vol,
    input  logic [NUM_SRC-1:0]           src_enable,
    output logic signed [SAMPLE_W-1:0]   mix_left,
    output logic signed [SAMPLE_W-1:0]   mix_right,
    output logic                         mix_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int STEP_W = $clog2(2 * NUM_SRC) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * NUM_SRC - 1);

    state_t                        state;
    logic [STEP_W-1:0]             step;
    logic [SAMPLE_W*NUM_SRC-1:0]   snap_left;
    logic [SAMPLE_W*NUM_SRC-1:0]   snap_right;
    logic [VOL_W*NUM_SRC-1:0]      snap_vol;
    logic [NUM_SRC-1:0]            snap_en;

    logic [STEP_W-1:0]             src_idx;
    logic signed [SAMPLE_W-1:0]    cur_sample;
    logic [VOL_W-1:0]              cur_vol;
    logic                          cur_en;
    logic                          mac_clear;
    logic                          mac_step;
    logic signed [ACC_W-1:0]       acc_left;
    logic signed [ACC_W-1:0]       acc_right;

    // Route the snapshotted source for the current step to the MAC: even steps left, odd steps right.
    always_comb begin
        src_idx    = step >> 1;
        cur_sample = '0;
        cur_vol    = '0;
        cur_en     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_idx == STEP_W'(i)) begin
                cur_sample = step[0] ? snap_right[SAMPLE_W*i +: SAMPLE_W]
                                     : snap_left[SAMPLE_W*i +: SAMPLE_W];
                cur_vol    = snap_vol[VOL_W*i +: VOL_W];
                cur_en     = snap_en[i];
            end
        end
        mac_clear = (state == ST_IDLE) && next_sample;
        mac_step  = (state == ST_ACC);
    end

    mix_mac #(
        .VOL_W (VOL_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clear     (mac_clear),
        .step_en   (mac_step),
        .chan      (step[0]),
        .sample    (cur_sample),
        .vol       (cur_vol),
        .enable    (cur_en),
        .acc_left  (acc_left),
        .acc_right (acc_right)
    );

    // Frame FSM: accept and snapshot in IDLE, walk 2*NUM_SRC steps in ACC, publish in SAT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            step       <= '0;
            snap_left  <= '0;
            snap_right <= '0;
            snap_vol   <= '0;
            snap_en    <= '0;
            mix_left   <= '0;
            mix_right  <= '0;
            mix_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (next_sample) begin
                        snap_left  <= src_left;
                        snap_right <= src_right;
                        snap_vol   <= src_vol;
                        snap_en    <= src_enable;
                        step       <= '0;
                        busy       <= 1'b1;
                        state      <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (next_sample) begin
                        overrun <= 1'b1;
                    end
                    if (step == LAST_STEP) begin
                        step  <= '0;
                        state <= ST_SAT;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                ST_SAT: begin
                    if (next_sample) begin
                        overrun <= 1'b1;
                    end
                    mix_left  <= sat_shift(acc_left);
                    mix_right <= sat_shift(acc_right);
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mix_sched.sv
// tb/tb_audio_mix_sched.sv - directed self-checking bench for audio_mix_sched
module tb_audio_mix_sched;

    localparam int N  = 4;
    localparam int VW = 5;

    typedef int vec4_t [4];

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 next_sample;
    logic [16*N-1:0]      src_left;
    logic [16*N-1:0]      src_right;
    logic [VW*N-1:0]      src_vol;
    logic [N-1:0]         src_enable;
    logic signed [15:0]   mix_left;
    logic signed [15:0]   mix_right;
    logic                 mix_valid;
    logic                 busy;
    logic                 overrun;

    int checks = 0;
    int errors = 0;
    int lat;
    int ovc;
    int vcnt;
    int bcnt;

    always #5 clk = ~clk;

    audio_mix_sched #(
        .NUM_SRC (N),
        .VOL_W   (VW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_sample (next_sample),
        .src_left    (src_left),
        .src_right   (src_right),
        .src_vol     (src_vol),
        .src_enable  (src_enable),
        .mix_left    (mix_left),
        .mix_right   (mix_right),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input vec4_t l, input vec4_t r, input vec4_t v, input logic [3:0] en);
        for (int i = 0; i < N; i++) begin
            src_left[16*i +: 16]  = 16'(l[i]);
            src_right[16*i +: 16] = 16'(r[i]);
            src_vol[VW*i +: VW]   = VW'(v[i]);
        end
        src_enable = en;
    endtask

    task automatic load_unity();
        load('{1000, 2000, -500, 0}, '{100, -200, 300, -400}, '{16, 16, 16, 16}, 4'b1111);
    endtask

    task automatic load_sat();
        load('{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768},
             '{16, 16, 16, 16}, 4'b1111);
    endtask

    task automatic load_gain();
        load('{1600, 100, 5000, 7777}, '{-17, 3, 9999, 1234}, '{8, 31, 16, 0}, 4'b1011);
    endtask

    // Called #1 after an edge. The accepting edge counts as edge 1; lat is the edge
    // count at which mix_valid is first seen. When alt is set the inputs are swapped
    // to the unity vectors one cycle after acceptance.
    task automatic run_frame(input bit alt, output int lat_o, output int ovc_o);
        int n;
        next_sample = 1'b1;
        @(posedge clk);
        #1;
        next_sample = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        if (alt) load_unity();
        n     = 1;
        ovc_o = int'(overrun);
        while (!mix_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (overrun) ovc_o++;
        end
        lat_o = n;
    endtask

    initial begin
        rst         = 1'b0;
        next_sample = 1'b0;
        load('{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mix_left",  int'(mix_left), 0);
        check("rst_mix_right", int'(mix_right), 0);
        check("rst_mix_valid", int'(mix_valid), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_overrun",   int'(overrun), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Unity mix
        load_unity();
        run_frame(1'b0, lat, ovc);
        check("unity_latency", lat, 10);
        check("unity_left",    int'(mix_left), 2500);
        check("unity_right",   int'(mix_right), -200);
        check("unity_overrun", ovc, 0);
        check("unity_busy_done", int'(busy), 0);

        // Saturation, accepted back-to-back in the first IDLE cycle
        load_sat();
        run_frame(1'b0, lat, ovc);
        check("sat_latency", lat, 10);
        check("sat_left",    int'(mix_left), 32767);
        check("sat_right",   int'(mix_right), -32768);
        check("sat_overrun", ovc, 0);
        @(posedge clk);
        #1;
        check("valid_one_cycle", int'(mix_valid), 0);
        check("hold_left",       int'(mix_left), 32767);

        // Gain clamp, zero gain, disable, floor rounding
        load_gain();
        run_frame(1'b0, lat, ovc);
        check("gain_latency", lat, 10);
        check("gain_left",    int'(mix_left), 900);
        check("gain_right",   int'(mix_right), -6);

        // Overrun: next_sample sampled on the third edge after acceptance
        load_unity();
        next_sample = 1'b1;
        @(posedge clk);
        #1;
        next_sample = 1'b0;
        ovc  = 0;
        vcnt = 0;
        lat  = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            next_sample = (c == 2);
            if (overrun) ovc++;
            if (mix_valid) begin
                vcnt++;
                if (lat == 0) lat = c + 1;
            end
        end
        next_sample = 1'b0;
        check("ovr_pulses",  ovc, 1);
        check("ovr_valids",  vcnt, 1);
        check("ovr_latency", lat, 10);
        check("ovr_left",    int'(mix_left), 2500);
        check("ovr_right",   int'(mix_right), -200);

        // Snapshot: inputs change one cycle after acceptance
        load_gain();
        run_frame(1'b1, lat, ovc);
        check("snap_latency", lat, 10);
        check("snap_left",    int'(mix_left), 900);
        check("snap_right",   int'(mix_right), -6);

        // Reset during ACC step 3, with next_sample asserted while in reset
        load_sat();
        next_sample = 1'b1;
        @(posedge clk);
        #1;
        next_sample = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b0;
        next_sample = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_left",    int'(mix_left), 0);
        check("midrst_right",   int'(mix_right), 0);
        check("midrst_valid",   int'(mix_valid), 0);
        check("midrst_busy",    int'(busy), 0);
        check("midrst_overrun", int'(overrun), 0);
        rst         = 1'b1;
        next_sample = 1'b0;
        vcnt = 0;
        ovc  = 0;
        bcnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (mix_valid) vcnt++;
            if (overrun) ovc++;
            if (busy) bcnt++;
        end
        check("postrst_valids",   vcnt, 0);
        check("postrst_overruns", ovc, 0);
        check("postrst_busy",     bcnt, 0);

        load_unity();
        run_frame(1'b0, lat, ovc);
        check("postrst_latency", lat, 10);
        check("postrst_left",    int'(mix_left), 2500);
        check("postrst_right",   int'(mix_right), -200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
